// File: rtl/lomo_frame_gen.sv
// Multi-lane framed serial generator: sync word, patterned payload and inter-frame gap on a divided bit clock.
// Optional build macro LOMO_FRAME_CRC_EN appends a per-lane CRC-8 word after the payload.
module lomo_frame_gen #(
    parameter int          CLK_DIV         = 20,
    parameter int          WORD_BITS       = 8,
    parameter int          WORDS_PER_FRAME = 4,
    parameter int          LANES           = 2,
    parameter int          GAP_BITS        = 4,
    parameter logic [31:0] SYNC_WORD       = 32'hE4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           pattern_sel,
    input  logic [WORD_BITS-1:0] const_word,
    output logic                 MK,
    output logic                 CLK,
    output logic [LANES-1:0]     DAT,
    output logic                 frame_done,
    output logic                 busy
);

`ifdef LOMO_FRAME_CRC_EN
    localparam int NW = WORDS_PER_FRAME + 1;
`else
    localparam int NW = WORDS_PER_FRAME;
`endif
    localparam int PW = $clog2(2 * CLK_DIV);
    localparam int BW = $clog2(WORD_BITS);
    localparam int KW = $clog2(NW);
    localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

    localparam logic [PW-1:0]        PH_LAST   = PW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0]        PH_HIGH   = PW'(CLK_DIV);
    localparam logic [BW-1:0]        BIT_LAST  = BW'(WORD_BITS - 1);
    localparam logic [KW-1:0]        WORD_LAST = KW'(NW - 1);
    localparam logic [GW-1:0]        GAP_LAST  = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam logic [WORD_BITS-1:0] SYNC_W    = SYNC_WORD[WORD_BITS-1:0];

    typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        phase_q, phase_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [KW-1:0]        word_q, word_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic [WORD_BITS-1:0] fcnt_q, fcnt_d;
    logic [1:0]           pat_q, pat_d;
    logic [WORD_BITS-1:0] const_q, const_d;
    logic                 bit_end;
    logic                 start_frame;
    logic [WORD_BITS-1:0] alt_w;

    assign bit_end = (phase_q == PH_LAST);

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        word_d      = word_q;
        gap_d       = gap_q;
        fcnt_d      = fcnt_q;
        pat_d       = pat_q;
        const_d     = const_q;
        start_frame = 1'b0;
        phase_d     = (state_q == IDLE || bit_end) ? '0 : phase_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (enable) start_frame = 1'b1;
            end
            FRAME: begin
                if (bit_end) begin
                    if (bit_q != BIT_LAST) begin
                        bit_d = bit_q + 1'b1;
                    end else begin
                        bit_d = '0;
                        if (word_q != WORD_LAST) begin
                            word_d = word_q + 1'b1;
                        end else begin
                            fcnt_d = fcnt_q + 1'b1;
                            if (GAP_BITS > 0) begin
                                state_d = GAP;
                                gap_d   = '0;
                            end else if (enable) begin
                                start_frame = 1'b1;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
            end
            GAP: begin
                if (bit_end) begin
                    if (gap_q != GAP_LAST)  gap_d = gap_q + 1'b1;
                    else if (enable)        start_frame = 1'b1;
                    else                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pattern inputs are captured only here so a frame is always self-consistent.
        if (start_frame) begin
            state_d = FRAME;
            bit_d   = '0;
            word_d  = '0;
            pat_d   = pattern_sel;
            const_d = const_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            word_q  <= '0;
            gap_q   <= '0;
            fcnt_q  <= '0;
            pat_q   <= '0;
            const_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            gap_q   <= gap_d;
            fcnt_q  <= fcnt_d;
            pat_q   <= pat_d;
            const_q <= const_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign CLK        = busy && (phase_q >= PH_HIGH);
    assign MK         = (state_q == FRAME) && (word_q == '0);
    assign frame_done = (state_q == FRAME) && bit_end && (bit_q == BIT_LAST) && (word_q == WORD_LAST);

    genvar gi;
    // Alternating word, MSB is always 1.
    for (gi = 0; gi < WORD_BITS; gi++) begin : g_alt
        assign alt_w[gi] = (((WORD_BITS - 1 - gi) % 2) == 0);
    end

    for (gi = 0; gi < LANES; gi++) begin : g_lane
        logic [WORD_BITS-1:0] pay_w;
        logic [WORD_BITS-1:0] word_w;
        logic                 bit_w;

        always_comb begin
            unique case (pat_q)
                2'd0:    pay_w = const_q;
                2'd1:    pay_w = WORD_BITS'(word_q);
                2'd2:    pay_w = fcnt_q + WORD_BITS'(gi);
                default: pay_w = alt_w;
            endcase
        end

`ifdef LOMO_FRAME_CRC_EN
        logic [7:0] crc_q;

        // CRC-8 poly 0x07 over payload bits only, shifted in as they leave the lane.
        always_ff @(posedge clk) begin
            if (reset || start_frame) begin
                crc_q <= '0;
            end else if (state_q == FRAME && bit_end && word_q != '0 && word_q != WORD_LAST) begin
                crc_q <= {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ bit_w) ? 8'h07 : 8'h00);
            end
        end

        always_comb begin
            if (word_q == '0)             word_w = SYNC_W;
            else if (word_q == WORD_LAST) word_w = WORD_BITS'(crc_q);
            else                          word_w = pay_w;
        end
`else
        always_comb begin
            if (word_q == '0) word_w = SYNC_W;
            else              word_w = pay_w;
        end
`endif

        assign bit_w   = word_w[BIT_LAST - bit_q];
        assign DAT[gi] = (state_q == FRAME) && bit_w;
    end

endmodule

// File: tb/tb_lomo_frame_gen.sv
// Randomized bench for lomo_frame_gen: a frame-timing model predicts every output on every clk cycle.
module tb_lomo_frame_gen;

    localparam int CD   = 20;
    localparam int WB   = 8;
    localparam int WPF  = 4;
    localparam int LN   = 2;
    localparam int GAPB = 4;
    localparam int SYNC = 'hE4;
    localparam int MASK = (1 << WB) - 1;
    localparam int BP   = 2 * CD;
`ifdef LOMO_FRAME_CRC_EN
    localparam int NWORDS = WPF + 1;
`else
    localparam int NWORDS = WPF;
`endif
    localparam int FB = NWORDS * WB;
    localparam int P  = (FB + GAPB) * BP;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [1:0]    pattern_sel;
    logic [WB-1:0] const_word;
    logic          mk, bclk, frame_done, busy;
    logic [LN-1:0] dat;

    lomo_frame_gen #(
        .CLK_DIV(CD), .WORD_BITS(WB), .WORDS_PER_FRAME(WPF),
        .LANES(LN), .GAP_BITS(GAPB), .SYNC_WORD(32'hE4)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
        .const_word(const_word), .MK(mk), .CLK(bclk), .DAT(dat),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int ecnt  = 0;
    bit m_act = 1'b0;
    int m_start, m_fcnt, m_pat, m_const;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int alt_word();
        int v = 0;
        for (int i = 0; i < WB; i++) v = (v << 1) | ((i % 2 == 0) ? 1 : 0);
        return v;
    endfunction

    function automatic int payload(int w, int lane);
        case (m_pat)
            0:       return m_const & MASK;
            1:       return w & MASK;
            2:       return (m_fcnt + lane) & MASK;
            default: return alt_word();
        endcase
    endfunction

`ifdef LOMO_FRAME_CRC_EN
    function automatic int crc_of(int lane);
        logic [7:0] c = 8'h00;
        int v;
        for (int w = 1; w < WPF; w++) begin
            v = payload(w, lane);
            for (int i = WB - 1; i >= 0; i--) begin
                if (c[7] ^ v[i]) c = {c[6:0], 1'b0} ^ 8'h07;
                else             c = {c[6:0], 1'b0};
            end
        end
        return int'(c);
    endfunction
`endif

    function automatic int exp_word(int w, int lane);
        if (w == 0) return SYNC & MASK;
`ifdef LOMO_FRAME_CRC_EN
        if (w == WPF) return crc_of(lane) & MASK;
`endif
        return payload(w, lane);
    endfunction

    function automatic logic [31:0] exp_outs();
        int o, b, ph, w, bi;
        logic e_clk, e_mk, e_done;
        logic [LN-1:0] e_dat;
        if (!m_act) return 32'd0;
        o      = ecnt - m_start;
        b      = o / BP;
        ph     = o % BP;
        e_clk  = (ph >= CD);
        e_mk   = 1'b0;
        e_done = 1'b0;
        e_dat  = '0;
        if (b < FB) begin
            w      = b / WB;
            bi     = b % WB;
            e_mk   = (w == 0);
            e_done = (b == FB - 1) && (ph == BP - 1);
            for (int l = 0; l < LN; l++) e_dat[l] = ((exp_word(w, l) >> (WB - 1 - bi)) & 1) != 0;
        end
        return 32'({1'b1, e_clk, e_mk, e_done, e_dat});
    endfunction

    task automatic model_start();
        m_act   = 1'b1;
        m_start = ecnt;
        m_pat   = pattern_sel;
        m_const = const_word;
    endtask

    // Frame n+1 begins exactly one frame-plus-gap period after frame n if enable is high then.
    task automatic model_edge();
        int o;
        ecnt++;
        if (reset) begin
            m_act  = 1'b0;
            m_fcnt = 0;
        end else if (!m_act) begin
            if (enable) model_start();
        end else begin
            o = ecnt - m_start;
            if (o == FB * BP) m_fcnt = (m_fcnt + 1) & MASK;
            if (o == P) begin
                if (enable) model_start();
                else        m_act = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk($sformatf("outs@%0d", ecnt), 32'({busy, bclk, mk, frame_done, dat}), exp_outs());
    endtask

    task automatic wait_start();
        bit found = 1'b0;
        for (int i = 0; i < 2 * P + 10 && !found; i++) begin
            step();
            if (m_act && ecnt == m_start) found = 1'b1;
        end
        chk("start_wait", 32'(found), 32'd1);
    endtask

    task automatic wait_done(output int e);
        bit found = 1'b0;
        e = -1;
        for (int i = 0; i < 2 * P + 10 && !found; i++) begin
            step();
            if (frame_done === 1'b1) begin
                found = 1'b1;
                e = ecnt;
            end
        end
        chk("done_wait", 32'(found), 32'd1);
        $display("frame_done at cycle %0d", e);
    endtask

    initial begin
        int e1, e2, s;
        bit fell;
        reset = 1'b1; enable = 1'b0; pattern_sel = 2'd0; const_word = '0;
        m_fcnt = 0; m_start = 0; m_pat = 0; m_const = 0;
        repeat (3) step();
        chk("rst_busy", 32'(busy), 32'd0);

        // Continuous constant pattern and frame period
        reset = 1'b0; enable = 1'b1; const_word = 8'h5A;
        step();
        chk("first_mk", 32'(mk), 32'd1);
        chk("first_dat", 32'(dat), 32'd3);
        wait_done(e1);
        wait_done(e2);
        chk("done_period", 32'(e2 - e1), 32'(P));

        // Pattern select changed mid-frame
        wait_start();
        repeat (5 * BP) step();
        pattern_sel = 2'd1;
        wait_done(e1);
        wait_done(e2);

        // Enable dropped at bit 10
        wait_start();
        s = ecnt;
        repeat (10 * BP) step();
        enable = 1'b0;
        fell = 1'b0;
        for (int i = 0; i < 2 * P && !fell; i++) begin
            step();
            if (busy === 1'b0) fell = 1'b1;
        end
        chk("drop_idle_at", 32'(ecnt - s), 32'(P));
        repeat (60) step();
        chk("idle_clk", 32'(bclk), 32'd0);

        // Reset at bit 20, then restart with counting pattern
        enable = 1'b1; pattern_sel = 2'd2;
        wait_start();
        repeat (20 * BP) step();
        reset = 1'b1;
        step();
        chk("rst_mid", 32'({busy, bclk, mk, frame_done, dat}), 32'd0);
        reset = 1'b0;
        step();
        chk("restart_mk", 32'(mk), 32'd1);
        repeat (3) wait_done(e1);

        // Random pattern, enable and reset activity
        for (int i = 0; i < 9000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                pattern_sel = 2'($urandom_range(0, 3));
                const_word  = WB'($urandom);
            end
            if ($urandom_range(0, 1999) == 0) enable = ~enable;
            reset = ($urandom_range(0, 4999) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
